// File: rtl/motor_cmd_arbiter_if.sv
// Command, proximity and status bundle between the robot's command sources and motor_cmd_arbiter.
// Strobes are fire-and-forget: IR_VALID / UART_VALID qualify their data for exactly one cycle, the arbiter samples every cycle and there is no ready/backpressure.
interface motor_cmd_arbiter_if #(
   parameter int PROX_W = 4,
   parameter int DUTY_W = 7,
   parameter int ERR_W  = 8
);
   logic              IR_VALID;
   logic [7:0]        IR_CODE;
   logic              UART_VALID;
   logic [7:0]        UART_BYTE;
   logic [PROX_W-1:0] PROX;
   logic [7:0]        SEND;
   logic [2:0]        MOTOR_STAT;
   logic [DUTY_W-1:0] DUTY;
   logic              CMD_SRC;
   logic              TIMEOUT;
   logic              OBSTACLE;
   logic [ERR_W-1:0]  ERR_CNT;
   logic [1:0]        STATE_DBG;

   modport master (
      output IR_VALID, IR_CODE, UART_VALID, UART_BYTE, PROX,
      input  SEND, MOTOR_STAT, DUTY, CMD_SRC, TIMEOUT, OBSTACLE, ERR_CNT, STATE_DBG
   );

   modport slave (
      input  IR_VALID, IR_CODE, UART_VALID, UART_BYTE, PROX,
      output SEND, MOTOR_STAT, DUTY, CMD_SRC, TIMEOUT, OBSTACLE, ERR_CNT, STATE_DBG
   );
endinterface

// File: rtl/motor_cmd_arbiter.sv
// Validates and arbitrates IR/UART motor commands, holds the drive state with a dead-man
// watchdog and derives PWM duty from proximity.
module motor_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int PROX_W         = 4,
   parameter int PROX_SLOW      = 8,
   parameter int PROX_STOP      = 3,
   parameter int DUTY_W         = 7,
   parameter int DUTY_FAST      = 60,
   parameter int DUTY_SLOW      = 40,
   parameter int ERR_W          = 8
) (
   input logic              CLK,
   input logic              RESET,
   motor_cmd_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_BRAKE   = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   // Command codes equal the MOTOR_STAT encoding; CMD_NONE doubles as "not a valid command".
   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_FWD   = 3'd1;
   localparam logic [2:0] CMD_LEFT  = 3'd2;
   localparam logic [2:0] CMD_BRAKE = 3'd3;
   localparam logic [2:0] CMD_RIGHT = 3'd4;
   localparam logic [2:0] CMD_BACK  = 3'd5;

   localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   localparam logic [DUTY_W-1:0] D_FAST = DUTY_W'(DUTY_FAST);
   localparam logic [DUTY_W-1:0] D_SLOW = DUTY_W'(DUTY_SLOW);
   localparam logic [PROX_W-1:0] P_SLOW = PROX_W'(PROX_SLOW);
   localparam logic [PROX_W-1:0] P_STOP = PROX_W'(PROX_STOP);

   state_t            state_q, state_d;
   logic [2:0]        cmd_q, cmd_d;
   logic              src_q, src_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              obst_q, obst_d;

   logic [2:0] ir_cmd, uart_cmd, sel_cmd;
   logic       sel_src, strobe;
   logic [2:0] stat;

   always_comb begin
      ir_cmd = CMD_NONE;
      if (bus.IR_CODE[7:4] == ~bus.IR_CODE[3:0]) begin
         case (bus.IR_CODE[3:0])
            4'd2:    ir_cmd = CMD_FWD;
            4'd4:    ir_cmd = CMD_LEFT;
            4'd5:    ir_cmd = CMD_BRAKE;
            4'd6:    ir_cmd = CMD_RIGHT;
            4'd8:    ir_cmd = CMD_BACK;
            default: ir_cmd = CMD_NONE;
         endcase
      end
      case (bus.UART_BYTE)
         8'h61:   uart_cmd = CMD_FWD;
         8'h62:   uart_cmd = CMD_LEFT;
         8'h63:   uart_cmd = CMD_BRAKE;
         8'h64:   uart_cmd = CMD_RIGHT;
         8'h65:   uart_cmd = CMD_BACK;
         default: uart_cmd = CMD_NONE;
      endcase
   end

   // IR wins a same-cycle collision; the losing UART byte is not counted as a reject.
   always_comb begin
      strobe  = bus.IR_VALID | bus.UART_VALID;
      sel_cmd = bus.IR_VALID ? ir_cmd : uart_cmd;
      sel_src = ~bus.IR_VALID;
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      src_d   = src_q;
      wd_d    = wd_q;
      err_d   = err_q;
      if (strobe && (sel_cmd != CMD_NONE)) begin
         cmd_d   = sel_cmd;
         src_d   = sel_src;
         wd_d    = '0;
         state_d = (sel_cmd == CMD_BRAKE) ? ST_BRAKE : ST_DRIVE;
      end else begin
         if (strobe && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
         end
         if (WD_EN && (state_q == ST_DRIVE)) begin
            if (wd_q == WD_LAST) begin
               state_d = ST_TIMEOUT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
      end
   end

   // Duty follows the registered state, so it lags a command or PROX change by one edge.
   always_comb begin
      duty_d = '0;
      obst_d = 1'b0;
      if (state_q == ST_DRIVE) begin
         case (cmd_q)
            CMD_BACK:            duty_d = D_SLOW;
            CMD_LEFT, CMD_RIGHT: duty_d = D_FAST;
            CMD_FWD: begin
               if (bus.PROX < P_STOP) begin
                  obst_d = 1'b1;
               end else if (bus.PROX < P_SLOW) begin
                  duty_d = D_SLOW;
               end else begin
                  duty_d = D_FAST;
               end
            end
            default: duty_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cmd_q   <= CMD_NONE;
         src_q   <= 1'b0;
         wd_q    <= '0;
         err_q   <= '0;
         duty_q  <= '0;
         obst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         src_q   <= src_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         duty_q  <= duty_d;
         obst_q  <= obst_d;
      end
   end

   always_comb begin
      stat = (state_q == ST_TIMEOUT) ? CMD_BRAKE : cmd_q;
      case (stat)
         CMD_FWD:   bus.SEND = 8'h02;
         CMD_LEFT:  bus.SEND = 8'h08;
         CMD_BRAKE: bus.SEND = 8'h10;
         CMD_RIGHT: bus.SEND = 8'h20;
         CMD_BACK:  bus.SEND = 8'h80;
         default:   bus.SEND = 8'h00;
      endcase
      bus.MOTOR_STAT = stat;
      bus.DUTY       = duty_q;
      bus.CMD_SRC    = src_q;
      bus.TIMEOUT    = (state_q == ST_TIMEOUT);
      bus.OBSTACLE   = obst_q;
      bus.ERR_CNT    = err_q;
      bus.STATE_DBG  = state_q;
   end

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Directed bench for motor_cmd_arbiter with a 100-cycle watchdog.
module tb_motor_cmd_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   motor_cmd_arbiter_if #(.PROX_W(4), .DUTY_W(7), .ERR_W(8)) bus ();

   motor_cmd_arbiter #(.TIMEOUT_CYCLES(100)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_ir(input logic [7:0] code);
      bus.IR_VALID = 1'b1; bus.IR_CODE = code;
      tick();
      bus.IR_VALID = 1'b0;
   endtask

   task automatic send_uart(input logic [7:0] b);
      bus.UART_VALID = 1'b1; bus.UART_BYTE = b;
      tick();
      bus.UART_VALID = 1'b0;
   endtask

   task automatic send_both(input logic [7:0] code, input logic [7:0] b);
      bus.IR_VALID = 1'b1; bus.IR_CODE = code;
      bus.UART_VALID = 1'b1; bus.UART_BYTE = b;
      tick();
      bus.IR_VALID = 1'b0; bus.UART_VALID = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++; if (bus.SEND !== 8'h00) begin errors++; $display("FAIL reset_send: got %h want 00", bus.SEND); end
      checks++; if (bus.MOTOR_STAT !== 3'd0) begin errors++; $display("FAIL reset_stat: got %0d want 0", bus.MOTOR_STAT); end
      checks++; if (bus.DUTY !== 7'd0 || bus.OBSTACLE !== 1'b0 || bus.TIMEOUT !== 1'b0 || bus.CMD_SRC !== 1'b0) begin
         errors++; $display("FAIL reset_misc: duty=%0d obst=%b to=%b src=%b want all 0", bus.DUTY, bus.OBSTACLE, bus.TIMEOUT, bus.CMD_SRC); end
      checks++; if (bus.ERR_CNT !== 8'd0 || bus.STATE_DBG !== 2'd0) begin
         errors++; $display("FAIL reset_err_state: err=%0d state=%0d want 0 0", bus.ERR_CNT, bus.STATE_DBG); end
   endtask

   task automatic test_ir_fwd();
      bus.PROX = 4'd15;
      send_ir(8'hD2);
      checks++; if (bus.SEND !== 8'h02) begin errors++; $display("FAIL ir_fwd_send: got %h want 02", bus.SEND); end
      checks++; if (bus.MOTOR_STAT !== 3'd1 || bus.CMD_SRC !== 1'b0) begin
         errors++; $display("FAIL ir_fwd_stat_src: got %0d/%b want 1/0", bus.MOTOR_STAT, bus.CMD_SRC); end
      checks++; if (bus.DUTY !== 7'd0) begin errors++; $display("FAIL ir_fwd_duty_lag: got %0d want 0", bus.DUTY); end
      tick();
      checks++; if (bus.DUTY !== 7'd60) begin errors++; $display("FAIL ir_fwd_duty: got %0d want 60", bus.DUTY); end
   endtask

   task automatic test_same_cycle();
      send_both(8'h78, 8'h61);
      checks++; if (bus.SEND !== 8'h80 || bus.CMD_SRC !== 1'b0) begin
         errors++; $display("FAIL both_send_src: got %h/%b want 80/0", bus.SEND, bus.CMD_SRC); end
      checks++; if (bus.ERR_CNT !== 8'd0) begin errors++; $display("FAIL both_err: got %0d want 0", bus.ERR_CNT); end
      tick();
      checks++; if (bus.DUTY !== 7'd40) begin errors++; $display("FAIL both_back_duty: got %0d want 40", bus.DUTY); end
      send_both(8'hD3, 8'h61);
      checks++; if (bus.SEND !== 8'h80 || bus.ERR_CNT !== 8'd1) begin
         errors++; $display("FAIL both_badir: send=%h err=%0d want 80 1", bus.SEND, bus.ERR_CNT); end
   endtask

   task automatic test_uart_reject();
      send_uart(8'h64);
      checks++; if (bus.SEND !== 8'h20 || bus.CMD_SRC !== 1'b1) begin
         errors++; $display("FAIL uart_right: got %h/%b want 20/1", bus.SEND, bus.CMD_SRC); end
      send_ir(8'hD3);
      checks++; if (bus.SEND !== 8'h20 || bus.CMD_SRC !== 1'b1 || bus.ERR_CNT !== 8'd2) begin
         errors++; $display("FAIL reject_badcheck: send=%h src=%b err=%0d want 20 1 2", bus.SEND, bus.CMD_SRC, bus.ERR_CNT); end
      send_ir(8'hC3);
      send_uart(8'h7A);
      checks++; if (bus.ERR_CNT !== 8'd4 || bus.MOTOR_STAT !== 3'd4) begin
         errors++; $display("FAIL reject_unmapped: err=%0d stat=%0d want 4 4", bus.ERR_CNT, bus.MOTOR_STAT); end
      bus.IR_VALID = 1'b1; bus.IR_CODE = 8'hD3;
      repeat (300) tick();
      bus.IR_VALID = 1'b0;
      checks++; if (bus.ERR_CNT !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d want 255", bus.ERR_CNT); end
      // Rejects never feed the watchdog, so the right turn has timed out by now.
      checks++; if (bus.TIMEOUT !== 1'b1 || bus.SEND !== 8'h10 || bus.MOTOR_STAT !== 3'd3) begin
         errors++; $display("FAIL reject_wd: to=%b send=%h stat=%0d want 1 10 3", bus.TIMEOUT, bus.SEND, bus.MOTOR_STAT); end
   endtask

   task automatic test_watchdog();
      send_uart(8'h61);
      checks++; if (bus.TIMEOUT !== 1'b0 || bus.SEND !== 8'h02 || bus.STATE_DBG !== 2'd1) begin
         errors++; $display("FAIL wd_recover: to=%b send=%h st=%0d want 0 02 1", bus.TIMEOUT, bus.SEND, bus.STATE_DBG); end
      repeat (99) tick();
      checks++; if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL wd_early: got %b want 0", bus.TIMEOUT); end
      tick();
      checks++; if (bus.TIMEOUT !== 1'b1 || bus.SEND !== 8'h10 || bus.DUTY !== 7'd60) begin
         errors++; $display("FAIL wd_fire: to=%b send=%h duty=%0d want 1 10 60", bus.TIMEOUT, bus.SEND, bus.DUTY); end
      tick();
      checks++; if (bus.DUTY !== 7'd0) begin errors++; $display("FAIL wd_duty: got %0d want 0", bus.DUTY); end
      send_ir(8'hD2);
      repeat (49) tick();
      send_ir(8'hD2);
      repeat (50) tick();
      checks++; if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL wd_restart_100: got %b want 0", bus.TIMEOUT); end
      repeat (49) tick();
      checks++; if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL wd_restart_149: got %b want 0", bus.TIMEOUT); end
      tick();
      checks++; if (bus.TIMEOUT !== 1'b1) begin errors++; $display("FAIL wd_restart_150: got %b want 1", bus.TIMEOUT); end
      send_ir(8'hA5);
      repeat (150) tick();
      checks++; if (bus.TIMEOUT !== 1'b0 || bus.STATE_DBG !== 2'd2 || bus.SEND !== 8'h10) begin
         errors++; $display("FAIL brake_no_wd: to=%b st=%0d send=%h want 0 2 10", bus.TIMEOUT, bus.STATE_DBG, bus.SEND); end
   endtask

   task automatic test_prox_sweep();
      logic [3:0] prox_v [7] = '{4'd15, 4'd5, 4'd2, 4'd9, 4'd3, 4'd8, 4'd7};
      logic [6:0] duty_v [7] = '{7'd60, 7'd40, 7'd0, 7'd60, 7'd40, 7'd60, 7'd40};
      bus.PROX = 4'd15;
      send_ir(8'hD2);
      for (int i = 0; i < 7; i++) begin
         bus.PROX = prox_v[i];
         tick();
         checks++; if (bus.DUTY !== duty_v[i] || bus.OBSTACLE !== (prox_v[i] < 4'd3) || bus.MOTOR_STAT !== 3'd1) begin
            errors++; $display("FAIL prox_%0d: duty=%0d obst=%b stat=%0d want %0d %b 1",
                               prox_v[i], bus.DUTY, bus.OBSTACLE, bus.MOTOR_STAT, duty_v[i], prox_v[i] < 4'd3); end
      end
      bus.PROX = 4'd2;
      send_ir(8'hB4);
      tick();
      checks++; if (bus.DUTY !== 7'd60 || bus.OBSTACLE !== 1'b0 || bus.SEND !== 8'h08) begin
         errors++; $display("FAIL left_near: duty=%0d obst=%b send=%h want 60 0 08", bus.DUTY, bus.OBSTACLE, bus.SEND); end
   endtask

   task automatic test_reset_mid();
      bus.PROX = 4'd15;
      send_uart(8'h61);
      tick();
      rst = 1'b1;
      send_uart(8'h62);
      rst = 1'b0;
      checks++; if (bus.SEND !== 8'h00 || bus.MOTOR_STAT !== 3'd0 || bus.DUTY !== 7'd0 || bus.CMD_SRC !== 1'b0) begin
         errors++; $display("FAIL mid_reset_out: send=%h stat=%0d duty=%0d src=%b want 00 0 0 0",
                            bus.SEND, bus.MOTOR_STAT, bus.DUTY, bus.CMD_SRC); end
      checks++; if (bus.ERR_CNT !== 8'd0 || bus.STATE_DBG !== 2'd0) begin
         errors++; $display("FAIL mid_reset_state: err=%0d st=%0d want 0 0", bus.ERR_CNT, bus.STATE_DBG); end
      repeat (150) tick();
      checks++; if (bus.TIMEOUT !== 1'b0 || bus.STATE_DBG !== 2'd0 || bus.SEND !== 8'h00) begin
         errors++; $display("FAIL idle_no_wd: to=%b st=%0d send=%h want 0 0 00", bus.TIMEOUT, bus.STATE_DBG, bus.SEND); end
   endtask

   initial begin
      bus.IR_VALID = 1'b0; bus.IR_CODE = 8'h00;
      bus.UART_VALID = 1'b0; bus.UART_BYTE = 8'h00;
      bus.PROX = 4'd0;
      @(negedge clk);
      test_reset();
      test_ir_fwd();
      test_same_cycle();
      test_uart_reject();
      test_watchdog();
      test_prox_sweep();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
